// File: rtl/ebike_spi_pkg.sv
// Shared definitions for the ebike SPI bench models: responder FSM states,
// frame layout and the noise LFSR constants.
package ebike_spi_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} a2d_state_t;

   localparam int FRAME_BITS  = 16;
   localparam int CH_ADDR_LSB = 11;
   localparam int CH_ADDR_MSB = 13;

   // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/spi_in_sync.sv
// Three-flop input conditioner for an asynchronous SPI line: two flops for
// metastability, a third to detect rising and falling edges in clk.
module spi_in_sync (
   input  logic clk,
   input  logic async_in,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   // Not reset: the chain must always follow the physical line so that a reset
   // taken while SS_n is low does not fabricate an edge afterwards.
   always_ff @(posedge clk) begin
      sr <= {sr[1:0], async_in};
   end

   assign sync = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling the 8-channel 12-bit A2D converter. The channel
// addressed in one frame is returned in the next. SCLK idles high; MISO is
// shifted on SCLK fall, MOSI sampled on SCLK rise.
// Optional build macro A2D_NOISE_EN: adds -4..+3 LFSR noise to returned values.
module a2d_spi_resp
   import ebike_spi_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int DATA_W     = 12,
   parameter int FRAME_BITS = 16
) (
   input  logic                     clk,
   input  logic                     RST_n,
   input  logic [NUM_CH*DATA_W-1:0] ch_vals,
   input  logic                     SS_n,
   input  logic                     SCLK,
   input  logic                     MOSI,
   output logic                     MISO,
   output logic                     frame_done,
   output logic                     frame_err,
   output logic [2:0]               last_ch
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

   logic ss_lvl_unused, ss_rise, ss_fall;
   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_in_sync u_ss   (.clk(clk), .async_in(SS_n), .sync(ss_lvl_unused),   .rise(ss_rise),          .fall(ss_fall));
   spi_in_sync u_sclk (.clk(clk), .async_in(SCLK), .sync(sclk_lvl_unused), .rise(sclk_rise),        .fall(sclk_fall));
   spi_in_sync u_mosi (.clk(clk), .async_in(MOSI), .sync(mosi_s),          .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   a2d_state_t               state;
   logic [CNT_W-1:0]         bit_cnt;
   logic [2:0]               ptr;
   logic [FRAME_BITS-1:0]    tx_shft;
   logic [CH_ADDR_MSB:0]     rx_shft;   // only bits up to the address field matter
   logic [DATA_W-1:0]        load_val;

   logic                     sclk_take;
   logic [CNT_W-1:0]         cnt_upd;
   logic [CH_ADDR_MSB:0]     rx_upd;
   logic [2:0]               addr_map;
   logic                     start_evt;
   logic                     done_evt;

   function automatic logic [DATA_W-1:0] ch_sel(input logic [NUM_CH*DATA_W-1:0] v,
                                                input logic [2:0] idx);
      return v[int'(idx)*DATA_W +: DATA_W];
   endfunction

`ifdef A2D_NOISE_EN
   logic [15:0] lfsr;

   // Adds the signed 3-bit noise and clamps into the converter's code range
   function automatic logic [DATA_W-1:0] sat_add_noise(input logic [DATA_W-1:0] v,
                                                       input logic [2:0] n);
      logic signed [DATA_W+1:0] sum;
      sum = $signed({2'b00, v}) + $signed({{(DATA_W-1){n[2]}}, n});
      if (sum < 0) return '0;
      if (sum > $signed({2'b00, {DATA_W{1'b1}}})) return '1;
      return sum[DATA_W-1:0];
   endfunction

   // Noise source steps once per completed frame
   always_ff @(posedge clk) begin
      if (!RST_n)        lfsr <= LFSR_SEED;
      else if (done_evt) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   assign load_val = sat_add_noise(ch_sel(ch_vals, ptr), lfsr[2:0]);
`else
   assign load_val = ch_sel(ch_vals, ptr);
`endif

   // SCLK rise is applied before any coincident SS_n rise is judged
   always_comb begin
      sclk_take = (state == SHIFT) && sclk_rise && (bit_cnt != CNT_FULL);
      cnt_upd   = sclk_take ? bit_cnt + 1'b1 : bit_cnt;
      rx_upd    = sclk_take ? {rx_shft[CH_ADDR_MSB-1:0], mosi_s} : rx_shft;
      addr_map  = rx_upd[CH_ADDR_MSB:CH_ADDR_LSB];
      if (int'(addr_map) >= NUM_CH) addr_map = 3'd0;
      start_evt = (state == IDLE) && ss_fall && !ss_rise;
      done_evt  = (state == SHIFT) && ss_rise && (cnt_upd == CNT_FULL);
   end

   // Control: frame state, bit counter, channel pointer and status pulses
   always_ff @(posedge clk) begin
      if (!RST_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         ptr        <= 3'd0;
         last_ch    <= 3'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_evt) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
               end
            end
            default: begin
               bit_cnt <= cnt_upd;
               if (ss_rise) begin
                  state <= IDLE;
                  if (done_evt) begin
                     ptr        <= addr_map;
                     last_ch    <= addr_map;
                     frame_done <= 1'b1;
                  end else if (cnt_upd != '0) begin
                     frame_err  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Data shifters: value captured at frame start, shifted out on SCLK fall
   always_ff @(posedge clk) begin
      if (start_evt)
         tx_shft <= {{(FRAME_BITS-DATA_W){1'b0}}, load_val};
      else if ((state == SHIFT) && sclk_fall && (bit_cnt != '0) && (bit_cnt != CNT_FULL))
         tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
      rx_shft <= rx_upd;
   end

   assign MISO = (state == SHIFT) && (bit_cnt != CNT_FULL) && tx_shft[FRAME_BITS-1];

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: drives SPI frames with SCLK idle high,
// captures MISO just before each SCLK rise and checks returned words,
// status pulses and last_ch against hand-computed values.
module tb_a2d_spi_resp;

   localparam int NUM_CH = 8;
   localparam int DATA_W = 12;

   logic                     clk = 1'b0;
   logic                     RST_n;
   logic [NUM_CH*DATA_W-1:0] ch_vals;
   logic                     SS_n;
   logic                     SCLK;
   logic                     MOSI;
   logic                     MISO;
   logic                     frame_done;
   logic                     frame_err;
   logic [2:0]               last_ch;

   int total = 0;
   int bad   = 0;
   int n_done = 0;
   int n_err  = 0;
   int d0, e0;
   logic [31:0] got;

   a2d_spi_resp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_BITS(16)) dut (
      .clk(clk), .RST_n(RST_n), .ch_vals(ch_vals), .SS_n(SS_n), .SCLK(SCLK),
      .MOSI(MOSI), .MISO(MISO), .frame_done(frame_done), .frame_err(frame_err),
      .last_ch(last_ch)
   );

   always #5 clk = ~clk;

   // Count clk cycles each pulse is high; a one-clk pulse adds exactly one
   always @(posedge clk) begin
      if (frame_done === 1'b1) n_done++;
      if (frame_err === 1'b1)  n_err++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
      ch_vals[k*DATA_W +: DATA_W] = v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // act_kind: 0 none, 1 write act_val to channel act_ch, 2 one-clk reset then abort
   task automatic xfer(input logic [15:0] mw, input int nbits, input int act_bit,
                       input int act_kind, input int act_ch, input logic [DATA_W-1:0] act_val);
      got = '0;
      SS_n = 1'b0;
      tick(8);
      for (int i = 0; i < nbits; i++) begin
         if (i == act_bit && act_kind == 1) set_ch(act_ch, act_val);
         if (i == act_bit && act_kind == 2) begin
            RST_n = 1'b0;
            tick(1);
            RST_n = 1'b1;
            chk("rst_miso", {31'd0, MISO}, 32'd0);
            chk("rst_last_ch", {29'd0, last_ch}, 32'd0);
            break;
         end
         SCLK = 1'b0;
         MOSI = (i < 16) ? mw[15-i] : 1'b1;
         tick(8);
         got = {got[30:0], MISO};
         SCLK = 1'b1;
         tick(8);
      end
      SS_n = 1'b1;
      tick(8);
   endtask

   initial begin
      RST_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; ch_vals = '0;
      set_ch(0, 12'h3A5);
      tick(4);
      chk("reset_miso",  {31'd0, MISO},       32'd0);
      chk("reset_done",  {31'd0, frame_done}, 32'd0);
      chk("reset_err",   {31'd0, frame_err},  32'd0);
      chk("reset_lastch",{29'd0, last_ch},    32'd0);
      RST_n = 1'b1;
      tick(4);

      // Frame 1: returns ch0, requests ch1
      d0 = n_done; e0 = n_err;
      xfer(16'h0800, 16, -1, 0, 0, '0);
      chk("f1_miso", got, 32'h0000_03A5);
      chk("f1_done", n_done - d0, 32'd1);
      chk("f1_err",  n_err - e0, 32'd0);
      chk("f1_last", {29'd0, last_ch}, 32'd1);

      // Frame 2: returns ch1 full scale, requests ch4
      set_ch(1, 12'hFFF);
      set_ch(4, 12'h5C3);
      d0 = n_done;
      xfer(16'h2000, 16, -1, 0, 0, '0);
      chk("f2_miso", got, 32'h0000_0FFF);
      chk("f2_last", {29'd0, last_ch}, 32'd4);
      chk("f2_done", n_done - d0, 32'd1);

      // Frame 3: returns ch4, requests ch6
      xfer(16'h3000, 16, -1, 0, 0, '0);
      chk("f3_miso", got, 32'h0000_05C3);
      chk("f3_last", {29'd0, last_ch}, 32'd6);

      // Short frame: 9 bits, error pulse, pointer stays at ch6
      set_ch(6, 12'h0AB);
      d0 = n_done; e0 = n_err;
      xfer(16'h1800, 9, -1, 0, 0, '0);
      chk("short_miso", got, 32'h0000_0001);
      chk("short_err",  n_err - e0, 32'd1);
      chk("short_done", n_done - d0, 32'd0);
      chk("short_last", {29'd0, last_ch}, 32'd6);
      xfer(16'h1000, 16, -1, 0, 0, '0);
      chk("after_short_miso", got, 32'h0000_00AB);
      chk("after_short_last", {29'd0, last_ch}, 32'd2);

      // Channel value changes mid-frame: captured value is kept
      set_ch(2, 12'h100);
      xfer(16'h1000, 16, 5, 1, 2, 12'h200);
      chk("midchg_miso", got, 32'h0000_0100);
      chk("midchg_last", {29'd0, last_ch}, 32'd2);
      xfer(16'h3800, 16, -1, 0, 0, '0);
      chk("newval_miso", got, 32'h0000_0200);
      chk("newval_last", {29'd0, last_ch}, 32'd7);

      // 20 SCLK pulses: extra bits read as 0, extra MOSI ones ignored
      set_ch(7, 12'h9E7);
      d0 = n_done; e0 = n_err;
      xfer(16'h2800, 20, -1, 0, 0, '0);
      chk("long_miso", got, 32'h0000_9E70);
      chk("long_done", n_done - d0, 32'd1);
      chk("long_last", {29'd0, last_ch}, 32'd5);

      // Reset mid-frame at bit 7: no status pulses, pointer back to ch0
      set_ch(0, 12'h456);
      d0 = n_done; e0 = n_err;
      xfer(16'h3800, 16, 7, 2, 0, '0);
      chk("rst_done", n_done - d0, 32'd0);
      chk("rst_err",  n_err - e0, 32'd0);
      xfer(16'h0800, 16, -1, 0, 0, '0);
      chk("post_rst_miso", got, 32'h0000_0456);
      chk("post_rst_last", {29'd0, last_ch}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
